// File: rtl/seg_scan_capture_if.sv
// Display bus bundle for the seven-segment read-back decoder: scanned bus
// inputs plus the decoded frame outputs.
interface seg_scan_capture_if;
  logic [5:0]  SCAN;
  logic [6:0]  SEVEN_SEGA;
  logic        DISP_DP;
  logic [23:0] O_DIGITS;
  logic [5:0]  O_DP;
  logic        O_FRAME_V;
  logic        O_GLYPH_ERR;
  logic        O_SCAN_ERR;
  logic        O_STALE;

  modport master (
    output SCAN, SEVEN_SEGA, DISP_DP,
    input  O_DIGITS, O_DP, O_FRAME_V, O_GLYPH_ERR, O_SCAN_ERR, O_STALE
  );

  modport slave (
    input  SCAN, SEVEN_SEGA, DISP_DP,
    output O_DIGITS, O_DP, O_FRAME_V, O_GLYPH_ERR, O_SCAN_ERR, O_STALE
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Seven-segment scan bus read-back: settles each scanned digit, decodes it to BCD
// and assembles a six-digit frame. Define SEG_CAP_DP_EN to compare and capture DISP_DP.
module seg_scan_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic               SYS_CLK,
  input  logic               SYS_RST_N,
  seg_scan_capture_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [8:0]    SETTLE_LIM = 9'(SETTLE_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [5:0]    scan_in_q, scan_prev_q;
  logic [6:0]    seg_in_q, seg_prev_q;
  logic          dp_in_q, dp_prev_q;
  logic          dp_raw;
  logic [5:0]    mask_q, mask_d;
  logic [23:0]   buf_q, buf_d;
  logic [5:0]    bdp_q, bdp_d;
  logic [23:0]   digits_q;
  logic [5:0]    dp_out_q;
  logic          frame_v_q, glyph_err_q, scan_err_q;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [5:0]    scan_low;
  logic          one_low, multi_low, changed, cap, frame_done;
  logic [2:0]    slot_idx;
  logic [6:0]    seg_norm;
  logic [3:0]    nib_dec;
  logic [5:0]    slot_bad;
  state_t        idle_state;
  logic [7:0]    idle_cnt;
  logic          idle_cap;
  logic [8:0]    cnt_inc;

`ifdef SEG_CAP_DP_EN
  assign dp_raw = bus.DISP_DP;
`else
  assign dp_raw = 1'b0;
`endif

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] r;
    case (s)
      7'h3F:   r = 4'd0;
      7'h06:   r = 4'd1;
      7'h5B:   r = 4'd2;
      7'h4F:   r = 4'd3;
      7'h66:   r = 4'd4;
      7'h6D:   r = 4'd5;
      7'h7D:   r = 4'd6;
      7'h07:   r = 4'd7;
      7'h7F:   r = 4'd8;
      7'h6F:   r = 4'd9;
      7'h00:   r = 4'hE;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  assign scan_low   = ~scan_in_q;
  assign multi_low  = (scan_low & (scan_low - 6'd1)) != 6'd0;
  assign one_low    = (scan_low != 6'd0) && !multi_low;
  assign changed    = (scan_in_q != scan_prev_q) || (seg_in_q != seg_prev_q) ||
                      (dp_in_q != dp_prev_q);
  assign seg_norm   = (SEG_ACT_LOW != 0) ? ~seg_in_q : seg_in_q;
  assign nib_dec    = seg_decode(seg_norm);
  assign frame_done = (mask_q == 6'h3F);
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    slot_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (scan_low[i]) slot_idx = 3'(i);
    end
  end

  // Shared "fresh sample" evaluation used by IDLE and by any bus change in SETTLE/HOLD.
  always_comb begin
    idle_state = IDLE;
    idle_cnt   = 8'd0;
    idle_cap   = 1'b0;
    if (one_low) begin
      idle_cnt = 8'd1;
      if (SETTLE_CYC <= 1) begin
        idle_state = HOLD;
        idle_cap   = 1'b1;
      end else begin
        idle_state = SETTLE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = idle_state;
        cnt_d   = idle_cnt;
        cap     = idle_cap;
      end
      SETTLE: begin
        if (changed) begin
          state_d = idle_state;
          cnt_d   = idle_cnt;
          cap     = idle_cap;
        end else if (cnt_inc >= SETTLE_LIM) begin
          state_d = HOLD;
          cap     = 1'b1;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = idle_state;
          cnt_d   = idle_cnt;
          cap     = idle_cap;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Completion clears the mask first so a same-cycle capture still lands in it.
  always_comb begin
    mask_d = frame_done ? 6'd0 : mask_q;
    buf_d  = buf_q;
    bdp_d  = bdp_q;
    if (cap) begin
      mask_d[slot_idx]              = 1'b1;
      buf_d[{slot_idx, 2'b00} +: 4] = nib_dec;
      bdp_d[slot_idx]               = dp_in_q;
    end
    if (frame_done)
      tmo_d = '0;
    else if (tmo_q != TMO_MAX)
      tmo_d = tmo_q + 1'b1;
    else
      tmo_d = tmo_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_slot
      assign slot_bad[gi] = (buf_q[gi*4 +: 4] == 4'hF);
    end
  endgenerate

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      scan_in_q   <= 6'h3F;
      scan_prev_q <= 6'h3F;
      seg_in_q    <= 7'd0;
      seg_prev_q  <= 7'd0;
      dp_in_q     <= 1'b0;
      dp_prev_q   <= 1'b0;
      mask_q      <= 6'd0;
      buf_q       <= 24'd0;
      bdp_q       <= 6'd0;
      digits_q    <= 24'd0;
      dp_out_q    <= 6'd0;
      frame_v_q   <= 1'b0;
      glyph_err_q <= 1'b0;
      scan_err_q  <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_in_q   <= bus.SCAN;
      scan_prev_q <= scan_in_q;
      seg_in_q    <= bus.SEVEN_SEGA;
      seg_prev_q  <= seg_in_q;
      dp_in_q     <= dp_raw;
      dp_prev_q   <= dp_in_q;
      mask_q      <= mask_d;
      buf_q       <= buf_d;
      bdp_q       <= bdp_d;
      frame_v_q   <= frame_done;
      scan_err_q  <= multi_low;
      tmo_q       <= tmo_d;
      if (frame_done) begin
        digits_q    <= buf_q;
        dp_out_q    <= bdp_q;
        glyph_err_q <= |slot_bad;
      end
    end
  end

  assign bus.O_DIGITS    = digits_q;
  assign bus.O_DP        = dp_out_q;
  assign bus.O_FRAME_V   = frame_v_q;
  assign bus.O_GLYPH_ERR = glyph_err_q;
  assign bus.O_SCAN_ERR  = scan_err_q;
  assign bus.O_STALE     = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans known frames over an active-low
// segment bus and checks frames, glyph/scan errors, reset and staleness.
module tb_seg_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;
  localparam int ACT_LOW = 1;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   frame_cnt = 0;
  int   serr_cnt  = 0;
  logic [23:0] last_digits = '0;
  logic [5:0]  last_dp = '0;
  logic        last_gerr = 1'b0;
  int          f0;
  int          s0;

  seg_scan_capture_if bus ();

  seg_scan_capture #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TIMEOUT),
    .SEG_ACT_LOW(ACT_LOW)
  ) dut (
    .SYS_CLK  (clk),
    .SYS_RST_N(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.O_FRAME_V === 1'b1) begin
      frame_cnt++;
      last_digits = bus.O_DIGITS;
      last_dp     = bus.O_DP;
      last_gerr   = bus.O_GLYPH_ERR;
      $display("frame: digits=%06h dp=%06b glyph_err=%0b", bus.O_DIGITS, bus.O_DP, bus.O_GLYPH_ERR);
    end
    if (bus.O_SCAN_ERR === 1'b1) serr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      $display("check %s: observed 0x%0h expected 0x%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_for(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      4'hE: return 7'h00;
      default: return 7'h49;
    endcase
  endfunction

  task automatic idle(input int n);
    bus.SCAN       = 6'h3F;
    bus.SEVEN_SEGA = (ACT_LOW != 0) ? 7'h7F : 7'h00;
    bus.DISP_DP    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_digit(input int idx, input logic [3:0] v, input logic dp, input int n);
    logic [5:0] s;
    logic [6:0] g;
    s = 6'h3F;
    s[idx] = 1'b0;
    g = seg_for(v);
    bus.SCAN       = s;
    bus.SEVEN_SEGA = (ACT_LOW != 0) ? ~g : g;
    bus.DISP_DP    = dp;
    repeat (n) tick();
  endtask

  task automatic scan_frame(input logic [23:0] val, input logic [5:0] dps);
    for (int i = 0; i < 6; i++) drive_digit(i, val[i*4 +: 4], dps[i], 10);
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    chk("rst_digits", 32'(bus.O_DIGITS), 32'h0);
    chk("rst_dp", 32'(bus.O_DP), 32'h0);
    chk("rst_frame_v", 32'(bus.O_FRAME_V), 32'h0);
    chk("rst_glyph_err", 32'(bus.O_GLYPH_ERR), 32'h0);
    chk("rst_scan_err", 32'(bus.O_SCAN_ERR), 32'h0);
    chk("rst_stale", 32'(bus.O_STALE), 32'h0);

    rst_n = 1'b1;
    repeat (TIMEOUT - 1) tick();
    chk("stale_before_timeout", 32'(bus.O_STALE), 32'h0);
    tick();
    chk("stale_at_timeout", 32'(bus.O_STALE), 32'h1);
    chk("no_frame_idle", 32'(frame_cnt), 32'd0);

    // 12:34:56
    f0 = frame_cnt;
    scan_frame(24'h123456, 6'b0);
    chk("frame1_count", 32'(frame_cnt - f0), 32'd1);
    chk("frame1_digits", 32'(last_digits), 32'h123456);
    chk("frame1_glyph_err", 32'(last_gerr), 32'h0);
    chk("frame1_stale_cleared", 32'(bus.O_STALE), 32'h0);

    // digit 2 shown too briefly, then rescanned with a different value
    f0 = frame_cnt;
    drive_digit(0, 4'd6, 1'b0, 10);
    drive_digit(1, 4'd5, 1'b0, 10);
    drive_digit(2, 4'd7, 1'b0, SETTLE - 1);
    drive_digit(3, 4'd3, 1'b0, 10);
    drive_digit(4, 4'd2, 1'b0, 10);
    drive_digit(5, 4'd1, 1'b0, 10);
    idle(3);
    chk("short_digit_no_frame", 32'(frame_cnt - f0), 32'd0);
    drive_digit(2, 4'd9, 1'b0, 10);
    idle(3);
    chk("rescan_frame_count", 32'(frame_cnt - f0), 32'd1);
    chk("rescan_digits", 32'(last_digits), 32'h123956);

    // bad glyph on digit 3, blank on digit 5
    f0 = frame_cnt;
    scan_frame(24'hE4F210, 6'b0);
    chk("glyph_frame_count", 32'(frame_cnt - f0), 32'd1);
    chk("glyph_digits", 32'(last_digits), 32'hE4F210);
    chk("glyph_err_set", 32'(last_gerr), 32'h1);
    scan_frame(24'hE87654, 6'b0);
    chk("blank_digits", 32'(last_digits), 32'hE87654);
    chk("blank_no_glyph_err", 32'(last_gerr), 32'h0);

    // two-low SCAN for two cycles
    f0 = frame_cnt;
    s0 = serr_cnt;
    bus.SCAN       = 6'b111100;
    bus.SEVEN_SEGA = ~seg_for(4'd8);
    repeat (2) tick();
    idle(4);
    chk("scan_err_pulses", 32'(serr_cnt - s0), 32'd2);
    chk("scan_err_no_frame", 32'(frame_cnt - f0), 32'd0);

    // reset after four digits discards the partial frame
    drive_digit(0, 4'd1, 1'b0, 10);
    drive_digit(1, 4'd2, 1'b0, 10);
    drive_digit(2, 4'd3, 1'b0, 10);
    drive_digit(3, 4'd4, 1'b0, 10);
    idle(1);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("midframe_rst_digits", 32'(bus.O_DIGITS), 32'h0);
    drive_digit(4, 4'd5, 1'b0, 10);
    drive_digit(5, 4'd0, 1'b0, 10);
    idle(3);
    chk("midframe_rst_no_frame", 32'(frame_cnt - f0), 32'd0);
    scan_frame(24'h054321, 6'b0);
    chk("fresh_frame_count", 32'(frame_cnt - f0), 32'd1);
    chk("fresh_frame_digits", 32'(last_digits), 32'h054321);

    // decimal points on digits 2 and 4
    f0 = frame_cnt;
    scan_frame(24'h235959, 6'b010100);
    chk("dp_frame_count", 32'(frame_cnt - f0), 32'd1);
`ifdef SEG_CAP_DP_EN
    chk("dp_captured", 32'(last_dp), 32'b010100);
`else
    chk("dp_ignored", 32'(last_dp), 32'b0);
`endif

    // DP toggling every cycle on digit 3, scanned last
    f0 = frame_cnt;
    drive_digit(0, 4'd0, 1'b0, 10);
    drive_digit(1, 4'd1, 1'b0, 10);
    drive_digit(2, 4'd2, 1'b0, 10);
    drive_digit(4, 4'd4, 1'b0, 10);
    drive_digit(5, 4'd0, 1'b0, 10);
    for (int k = 0; k < 10; k++) drive_digit(3, 4'd3, k[0], 1);
    idle(3);
`ifdef SEG_CAP_DP_EN
    chk("dp_toggle_blocks_capture", 32'(frame_cnt - f0), 32'd0);
    drive_digit(3, 4'd3, 1'b0, 10);
    idle(3);
    chk("dp_toggle_then_steady", 32'(frame_cnt - f0), 32'd1);
`else
    chk("dp_toggle_ignored", 32'(frame_cnt - f0), 32'd1);
`endif
    chk("dp_toggle_digits", 32'(last_digits), 32'h043210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
